// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared mode encodings and elaboration helpers for the N-to-1 arbiter mux
package mux_arb_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: grants the first requester after ptr, wrapping modulo N
module rr_priority_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any_grant
);

    int c;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        c         = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any_grant && req[c]) begin
                any_grant = 1'b1;
                idx       = W'(c);
                grant[c]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter_nto1.sv
// mux_arbiter_nto1: registered N-to-1 mux with external-select or round-robin arbitration
module mux_arbiter_nto1
    import mux_arb_pkg::*;
#(
    parameter int NBits     = 32,
    parameter int NChannels = 4,
    parameter int SelBits   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Mode,
    input  logic [SelBits-1:0]         Selector,
    input  logic [NChannels-1:0]       In_Valid,
    input  logic [NChannels*NBits-1:0] In_Data,
    output logic [NChannels-1:0]       In_Ready,
    output logic                       Out_Valid,
    output logic [NBits-1:0]           Out_Data,
    output logic [SelBits-1:0]         Out_Channel,
    input  logic                       Out_Ready
);

    if (clog2(NChannels) > SelBits) begin : g_bad_selbits
        $error("SelBits too narrow for NChannels");
    end

    logic [NBits-1:0]     ch_data [NChannels];
    logic [NChannels-1:0] rr_grant;
    logic [NChannels-1:0] sel_onehot;
    logic [NChannels-1:0] grant;
    logic [SelBits-1:0]   rr_idx;
    logic [SelBits-1:0]   rr_ptr;
    logic [SelBits-1:0]   grant_idx;
    logic                 rr_any;
    logic                 load_en;
    logic                 grant_any;

    for (genvar i = 0; i < NChannels; i++) begin : g_ch
        assign ch_data[i] = In_Data[i*NBits +: NBits];
    end

    rr_priority_picker #(
        .N(NChannels),
        .W(SelBits)
    ) u_picker (
        .req      (In_Valid),
        .ptr      (rr_ptr),
        .grant    (rr_grant),
        .idx      (rr_idx),
        .any_grant(rr_any)
    );

    // Out-of-range selectors shift the one-hot out of the vector, so they never grant
    always_comb begin
        load_en    = !Out_Valid || Out_Ready;
        sel_onehot = NChannels'(1) << Selector;
        grant      = (reset || !load_en) ? '0 :
                     (Mode == MODE_RR)   ? rr_grant : sel_onehot & In_Valid;
        grant_any  = |grant;
        grant_idx  = (Mode == MODE_RR) ? rr_idx : Selector;
    end

    assign In_Ready = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            Out_Valid   <= 1'b0;
            Out_Data    <= '0;
            Out_Channel <= '0;
            rr_ptr      <= SelBits'(NChannels - 1);
        end else begin
            if (grant_any) begin
                Out_Valid   <= 1'b1;
                Out_Data    <= ch_data[grant_idx];
                Out_Channel <= grant_idx;
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
            if (grant_any && Mode == MODE_RR && rr_any) rr_ptr <= rr_idx;
        end
    end

    logic unused_ok;
    assign unused_ok = rr_any;

endmodule

// File: tb/tb_mux_arbiter_nto1.sv
// tb_mux_arbiter_nto1: scoreboard bench for the registered N-to-1 arbiter mux
module tb_mux_arbiter_nto1;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  selector;
    logic [3:0]  in_valid;
    logic [31:0] d [4];
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_channel;
    logic        out_ready;

    logic [1:0]  sel3;
    logic [2:0]  valid3;
    logic [2:0]  ready3;
    logic        out_valid3;
    logic [31:0] out_data3;
    logic [1:0]  out_channel3;

    int errors = 0;
    int checks = 0;
    logic [33:0] sb_q [$];
    int m_rr;

    always #5 clk = ~clk;

    mux_arbiter_nto1 #(.NBits(32), .NChannels(4), .SelBits(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .Mode       (mode),
        .Selector   (selector),
        .In_Valid   (in_valid),
        .In_Data    ({d[3], d[2], d[1], d[0]}),
        .In_Ready   (in_ready),
        .Out_Valid  (out_valid),
        .Out_Data   (out_data),
        .Out_Channel(out_channel),
        .Out_Ready  (out_ready)
    );

    mux_arbiter_nto1 #(.NBits(32), .NChannels(3), .SelBits(2)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .Mode       (mode),
        .Selector   (sel3),
        .In_Valid   (valid3),
        .In_Data    ({d[2], d[1], d[0]}),
        .In_Ready   (ready3),
        .Out_Valid  (out_valid3),
        .Out_Data   (out_data3),
        .Out_Channel(out_channel3),
        .Out_Ready  (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock of the reference model: check outputs, predict grant, then advance
    task automatic cycle();
        logic [3:0] eg;
        int gi;
        #1;
        eg = '0;
        gi = -1;
        check("out_valid", out_valid, sb_q.size() != 0);
        if (sb_q.size() != 0) begin
            check("out_data", out_data, sb_q[0][31:0]);
            check("out_channel", out_channel, sb_q[0][33:32]);
        end
        if (!reset && (sb_q.size() == 0 || out_ready)) begin
            if (mode) begin
                for (int k = 1; k <= 4; k++)
                    if (gi < 0 && in_valid[(m_rr + k) % 4]) gi = (m_rr + k) % 4;
            end else if (in_valid[selector]) begin
                gi = int'(selector);
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        check("in_ready", in_ready, eg);
        if (reset) begin
            sb_q.delete();
            m_rr = 3;
        end else begin
            if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
            if (gi >= 0) begin
                sb_q.push_back({2'(gi), d[gi]});
                if (mode) m_rr = gi;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 1'b1;
        selector  = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        sel3      = 2'd0;
        valid3    = 3'b111;
        m_rr      = 3;
        for (int i = 0; i < 4; i++) d[i] = 32'(10 + i);
        @(posedge clk);
        #1;
        check("reset_out_data", out_data, 32'd0);
        cycle();
        cycle();
        check("reset_out_data2", out_data, 32'd0);
        check("reset_out_valid3", out_valid3, 1'b0);
        reset = 1'b0;

        // Round-robin fairness: all valid, first grant channel 0
        repeat (8) cycle();
        in_valid = 4'b0000;
        cycle();
        cycle();

        // External select of channel 2
        mode     = 1'b0;
        selector = 2'd2;
        d[2]     = 32'hDEADBEEF;
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b0000;
        cycle();
        cycle();

        // Three-channel instance: valid select then out-of-range select
        valid3 = 3'b111;
        sel3   = 2'd1;
        #1;
        check("dut3_ready_sel1", ready3, 3'b010);
        cycle();
        check("dut3_out_valid", out_valid3, 1'b1);
        check("dut3_out_channel", out_channel3, 2'd1);
        check("dut3_out_data", out_data3, 32'd11);
        sel3 = 2'd3;
        #1;
        check("dut3_ready_sel3", ready3, 3'b000);
        cycle();
        check("dut3_drained", out_valid3, 1'b0);

        // Back-pressure then drain-and-reload without a bubble
        mode     = 1'b1;
        d[2]     = 32'd12;
        in_valid = 4'b1111;
        cycle();
        out_ready = 1'b0;
        repeat (3) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();
        in_valid = 4'b0000;
        cycle();
        cycle();

        // Sparse requesters 1 and 3 starting from rr_ptr = 3
        in_valid = 4'b1000;
        cycle();
        in_valid = 4'b0000;
        cycle();
        in_valid = 4'b1010;
        repeat (3) cycle();
        out_ready = 1'b0;
        mode      = 1'b0;
        selector  = 2'd0;
        in_valid  = 4'b1011;
        repeat (2) cycle();
        out_ready = 1'b1;
        cycle();
        cycle();

        // Reset mid-transfer discards the held word and the pending grant
        mode     = 1'b1;
        in_valid = 4'b1111;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        in_valid = 4'b0000;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
